multicycle_cpu: RTL and testbench



---
 rtl/multicycle_cpu_pkg.sv | 34 +++
 rtl/multicycle_cpu_alu.sv | 33 +++
 rtl/multicycle_cpu.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_cpu_pkg.sv
// Shared opcode, FSM state and flag-index constants
// for the multi-cycle core and its ALU.
package multicycle_cpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_ADDI = 5'h06;
  localparam logic [4:0] OP_MOVI = 5'h07;
  localparam logic [4:0] OP_MOV  = 5'h08;
  localparam logic [4:0] OP_LD   = 5'h09;
  localparam logic [4:0] OP_ST   = 5'h0A;
  localparam logic [4:0] OP_CMP  = 5'h0B;
  localparam logic [4:0] OP_JMP  = 5'h0C;
  localparam logic [4:0] OP_JZ   = 5'h0D;
  localparam logic [4:0] OP_JNZ  = 5'h0E;
  localparam logic [4:0] OP_JL   = 5'h0F;
  localparam logic [4:0] OP_JG   = 5'h10;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam int FLAG_G = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/multicycle_cpu_alu.sv
// cpu_alu: combinational ALU. Ports: op, a, b in;
// result and {G,L,Z} flags out.
module cpu_alu
  import multicycle_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        flags
);

  always_comb begin
    result = '0;
    flags  = '0;
    unique case (op)
      OP_ADD, OP_ADDI: result = a + b;
      OP_SUB, OP_CMP: begin
        result        = a - b;
        flags[FLAG_L] = a < b;
        flags[FLAG_G] = a > b;
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle core: loader handshake, IDLE/FETCH/EXEC/MEM/HALT FSM.
// Ports: clk/rst, load_*, start, busy/halted/pc/flags/instr_count, dbg_*.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter int RSEL_W = 2,
  localparam int INSTR_W = 5 + 2*RSEL_W + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  output logic               busy,
  output logic               halted,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         flags,
  output logic [15:0]        instr_count,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  logic [2:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  dm_q;

  logic [INSTR_W-1:0] imem [2**PC_W];
  logic [DATA_W-1:0]  dmem [2**DATA_W];
  logic [DATA_W-1:0]  rf   [2**RSEL_W];

  logic [4:0]        op;
  logic [RSEL_W-1:0] rd;
  logic [RSEL_W-1:0] rs;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   target;

  assign op     = ir[INSTR_W-1 -: 5];
  assign rd     = ir[INSTR_W-6 -: RSEL_W];
  assign rs     = ir[INSTR_W-6-RSEL_W -: RSEL_W];
  assign imm    = ir[DATA_W-1:0];
  assign target = ir[PC_W-1:0];

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [2:0]        alu_flags;

  assign rd_val = rf[rd];
  assign rs_val = rf[rs];
  assign alu_b  = (op == OP_ADDI) ? imm : rs_val;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_res),
    .flags  (alu_flags)
  );

  logic              rf_we;
  logic              fl_we;
  logic [DATA_W-1:0] rf_wd;
  logic              taken;

  always_comb begin
    rf_we = 1'b0;
    fl_we = 1'b0;
    rf_wd = alu_res;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: begin
        rf_we = 1'b1;
        fl_we = 1'b1;
      end
      OP_CMP: fl_we = 1'b1;
      OP_MOVI: begin
        rf_we = 1'b1;
        rf_wd = imm;
      end
      OP_MOV: begin
        rf_we = 1'b1;
        rf_wd = rs_val;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // Jumps never write flags, so the held flags are the EXEC-start flags.
  always_comb begin
    taken = 1'b0;
    unique case (op)
      OP_JMP: taken = 1'b1;
      OP_JZ:  taken = flags[FLAG_Z];
      OP_JNZ: taken = ~flags[FLAG_Z];
      OP_JL:  taken = flags[FLAG_L];
      OP_JG:  taken = flags[FLAG_G];
      default: taken = 1'b0;
    endcase
  end

  logic            last;
  logic [15:0]     cnt_inc;
  logic [PC_W-1:0] pc_seq;

  assign last    = (pc == '1);
  assign pc_seq  = pc + 1'b1;
  assign cnt_inc = (instr_count == 16'hFFFF) ?
                   instr_count : instr_count + 16'd1;

  assign load_ready = (state == S_IDLE) || (state == S_HALT);
  assign busy       = (state == S_FETCH) || (state == S_EXEC) ||
                      (state == S_MEM);
  assign halted     = (state == S_HALT);
  assign dbg_data   = rf[dbg_sel];

  always_ff @(posedge clk) begin
    if (load_valid && load_ready)
      imem[load_addr] <= load_data;
    if (state == S_FETCH)
      ir <= imem[pc];
    if (!rst && state == S_EXEC && op == OP_ST)
      dmem[rs_val] <= rd_val;
    if (state == S_EXEC)
      dm_q <= dmem[rs_val];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      flags       <= '0;
      instr_count <= '0;
      for (int i = 0; i < 2**RSEL_W; i++)
        rf[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            flags       <= '0;
            instr_count <= '0;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          if (op == OP_LD) begin
            state <= S_MEM;
          end else begin
            instr_count <= cnt_inc;
            if (rf_we) rf[rd] <= rf_wd;
            if (fl_we) flags <= alu_flags;
            if (op == OP_HALT || (last && !taken)) begin
              state <= S_HALT;
            end else begin
              state <= S_FETCH;
              pc    <= taken ? target : pc_seq;
            end
          end
        end
        S_MEM: begin
          instr_count <= cnt_inc;
          rf[rd]      <= dm_q;
          if (last) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
            pc    <= pc_seq;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: instruction-level ISA model,
// directed programs plus random straight-line programs.
module tb_multicycle_cpu;

  localparam int IW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [7:0]    load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          halted;
  logic [7:0]    pc;
  logic [2:0]    flags;
  logic [15:0]   instr_count;
  logic [1:0]    dbg_sel = '0;
  logic [7:0]    dbg_data;

  multicycle_cpu dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .busy        (busy),
    .halted      (halted),
    .pc          (pc),
    .flags       (flags),
    .instr_count (instr_count),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [IW-1:0] m_imem [256];
  logic [7:0]    m_dm [256];
  logic [7:0]    m_rf [4];
  logic [2:0]    m_fl;
  int            m_pc;
  int            m_cnt;

  function automatic logic [IW-1:0] enc(int op, int rd, int rs, int imm);
    return {5'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd_reg(input int r, output logic [7:0] v);
    dbg_sel = 2'(r);
    #1;
    v = dbg_data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_fl = '0;
    m_pc = 0;
    m_cnt = 0;
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    @(negedge clk);
    chk("load_ready", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_addr = 8'(a);
    load_data = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    m_imem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Executes one instruction of the ISA; returns cycle cost.
  task automatic model_step(output int lat, output bit done);
    logic [IW-1:0] w;
    int op, rd, rs, imm, a, b, r;
    bit tk, hlt;
    w = m_imem[m_pc];
    op = int'(w[16:12]);
    rd = int'(w[11:10]);
    rs = int'(w[9:8]);
    imm = int'(w[7:0]);
    a = int'(m_rf[rd]);
    b = int'(m_rf[rs]);
    tk = 1'b0;
    hlt = 1'b0;
    lat = 2;
    done = 1'b0;
    r = 0;
    case (op)
      1: begin r = (a + b) % 256; m_rf[rd] = 8'(r); m_fl = {2'b00, r == 0}; end
      2: begin
        r = (a - b + 256) % 256;
        m_rf[rd] = 8'(r);
        m_fl = {a > b, a < b, r == 0};
      end
      3: begin r = a & b; m_rf[rd] = 8'(r); m_fl = {2'b00, r == 0}; end
      4: begin r = a | b; m_rf[rd] = 8'(r); m_fl = {2'b00, r == 0}; end
      5: begin r = a ^ b; m_rf[rd] = 8'(r); m_fl = {2'b00, r == 0}; end
      6: begin r = (a + imm) % 256; m_rf[rd] = 8'(r); m_fl = {2'b00, r == 0}; end
      7: m_rf[rd] = 8'(imm);
      8: m_rf[rd] = 8'(b);
      9: begin m_rf[rd] = m_dm[b]; lat = 3; end
      10: m_dm[b] = 8'(a);
      11: begin r = (a - b + 256) % 256; m_fl = {a > b, a < b, r == 0}; end
      12: tk = 1'b1;
      13: tk = m_fl[0];
      14: tk = !m_fl[0];
      15: tk = m_fl[1];
      16: tk = m_fl[2];
      31: hlt = 1'b1;
      default: ;
    endcase
    if (m_cnt < 65535) m_cnt++;
    if (hlt) done = 1'b1;
    else if (tk) m_pc = imm;
    else if (m_pc == 255) done = 1'b1;
    else m_pc++;
  endtask

  task automatic check_state(input bit done);
    logic [7:0] v;
    chk("pc", 32'(pc), 32'(m_pc));
    chk("flags", 32'(flags), 32'(m_fl));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    chk("halted", 32'(halted), 32'(done));
    chk("busy", 32'(busy), 32'(!done));
    chk("load_ready", 32'(load_ready), 32'(done));
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      chk("reg", 32'(v), 32'(m_rf[i]));
    end
  endtask

  // Pulses start, then tracks the DUT cycle by cycle against the model.
  task automatic run(input bit noise, input bit sl,
                     input logic [IW-1:0] sl_data, output int cycles);
    int lat, steps;
    bit done;
    @(negedge clk);
    start = 1'b1;
    if (sl) begin
      load_valid = 1'b1;
      load_addr = '0;
      load_data = sl_data;
      m_imem[0] = sl_data;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    load_valid = 1'b0;
    m_pc = 0;
    m_fl = '0;
    m_cnt = 0;
    cycles = 0;
    steps = 0;
    done = 1'b0;
    while (!done && steps < 4000) begin
      model_step(lat, done);
      steps++;
      for (int c = 0; c < lat; c++) begin
        if (c == 0 && noise) begin
          load_valid = 1'b1;
          load_addr = 8'd5;
          load_data = enc(31, 0, 0, 0);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        cycles++;
        if (c < lat - 1) begin
          chk("busy_mid", 32'(busy), 1);
          chk("ready_mid", 32'(load_ready), 0);
        end
      end
      check_state(done);
    end
    if (!done) chk("run_budget", 0, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [7:0] v;
    int opl [20] = '{1, 2, 3, 4, 5, 6, 7, 7, 8, 9,
                     10, 11, 12, 13, 14, 15, 16, 0, 19, 31};
    int op, imm;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_cnt", 32'(instr_count), 0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(i, v);
      chk("rst_reg", 32'(v), 0);
    end

    load(0, enc(7, 0, 0, 5));
    load(1, enc(7, 1, 0, 3));
    load(2, enc(1, 0, 1, 0));
    load(3, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    chk("t1_cycles", 32'(cyc), 8);
    rd_reg(0, v);
    chk("t1_r0", 32'(v), 8);
    chk("t1_flags", 32'(flags), 0);
    chk("t1_cnt", 32'(instr_count), 4);

    load(0, enc(2, 0, 0, 0));
    load(1, enc(13, 0, 0, 10));
    load(2, enc(7, 2, 0, 7));
    load(10, enc(7, 2, 0, 1));
    load(11, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    rd_reg(2, v);
    chk("t2_r2", 32'(v), 1);
    chk("t2_pc", 32'(pc), 11);

    load(0, enc(7, 0, 0, 3));
    load(1, enc(7, 1, 0, 7));
    load(2, enc(11, 0, 1, 0));
    load(3, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    chk("t3_cmp_flags", 32'(flags), 32'b010);
    load(3, enc(16, 0, 0, 20));
    load(4, enc(15, 0, 0, 30));
    load(5, enc(31, 0, 0, 0));
    load(20, enc(7, 3, 0, 8'h55));
    load(21, enc(31, 0, 0, 0));
    load(30, enc(7, 3, 0, 8'hAA));
    load(31, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    rd_reg(3, v);
    chk("t3_r3", 32'(v), 32'hAA);
    chk("t3_pc", 32'(pc), 31);
    load(0, enc(7, 0, 0, 8'hFF));
    load(1, enc(6, 0, 0, 1));
    load(2, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    rd_reg(0, v);
    chk("t3_addi_r0", 32'(v), 0);
    chk("t3_addi_flags", 32'(flags), 32'b001);

    // Fill data memory with dm[i]=i so later loads are defined.
    load(0, enc(7, 0, 0, 0));
    load(1, enc(10, 0, 0, 0));
    load(2, enc(6, 0, 0, 1));
    load(3, enc(14, 0, 0, 1));
    load(4, enc(31, 0, 0, 0));
    for (int i = 0; i < 256; i++) m_dm[i] = 8'(i);
    run(0, 0, '0, cyc);
    chk("fill_cnt", 32'(instr_count), 770);

    load(0, enc(7, 0, 0, 4));
    load(1, enc(7, 1, 0, 9));
    load(2, enc(10, 1, 0, 0));
    load(3, enc(9, 2, 0, 0));
    load(4, enc(31, 0, 0, 0));
    run(0, 0, '0, cyc);
    rd_reg(2, v);
    chk("t4_r2", 32'(v), 9);
    chk("t4_cycles", 32'(cyc), 11);

    for (int a = 0; a < 256; a++) begin
      op = ($urandom_range(0, 1) == 0) ? 0 : 17 + $urandom_range(0, 13);
      load(a, enc(op, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 255)));
    end
    run(1, 0, '0, cyc);
    chk("t5_pc", 32'(pc), 255);
    chk("t5_cnt", 32'(instr_count), 256);
    chk("t5_cycles", 32'(cyc), 512);

    load(0, enc(7, 0, 0, 5));
    load(1, enc(7, 1, 0, 3));
    load(2, enc(1, 0, 1, 0));
    load(3, enc(31, 0, 0, 0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    do_reset();
    chk("t6_ready", 32'(load_ready), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_halted", 32'(halted), 0);
    chk("t6_pc", 32'(pc), 0);
    chk("t6_cnt", 32'(instr_count), 0);
    rd_reg(0, v);
    chk("t6_r0", 32'(v), 0);
    run(0, 0, '0, cyc);
    rd_reg(0, v);
    chk("t6_rerun_r0", 32'(v), 8);
    chk("t6_rerun_cycles", 32'(cyc), 8);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int a = 0; a < 15; a++) begin
        op = opl[$urandom_range(0, 19)];
        if (op >= 12 && op <= 16) imm = $urandom_range(a + 1, 15);
        else imm = $urandom_range(0, 255);
        load(a, enc(op, $urandom_range(0, 3), $urandom_range(0, 3), imm));
      end
      load(15, enc(31, 0, 0, 0));
      run(0, 1'($urandom_range(0, 1)),
          enc(7, $urandom_range(0, 3), 0, $urandom_range(0, 255)), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
